// File: rtl/fifo_pkt.sv
// Synchronous FIFO with streaming or store-and-forward packet mode, committed-packet
// counter, forced commit for over-long packets and optional output register; FIFO_PKT_LEVEL_EN adds the level port.
module fifo_pkt #(
  parameter int DEPTH   = 64,
  parameter int DIN     = 16,
  parameter int EOT_BIT = DIN - 1,
  parameter int MODE    = 1,
  parameter int REGOUT  = 0,
  localparam int CW     = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [DIN-1:0] din_data,
  input  logic           din_valid,
  output logic           din_ready,
  output logic [DIN-1:0] dout_data,
  output logic           dout_valid,
  input  logic           dout_ready,
  output logic [CW:0]    pkt_cnt
`ifdef FIFO_PKT_LEVEL_EN
  ,
  output logic [CW:0]    level
`endif
);

  localparam logic [CW:0] ONE = (CW + 1)'(1);

  logic [DIN-1:0] ram [DEPTH];
  logic [CW:0]    waddr, caddr, raddr;
  logic [CW:0]    waddr_nxt, raddr_nxt;
  logic [DIN-1:0] rd_word;
  logic           full, avail, out_ready;
  logic           wr, rd, wr_eot, rd_eot;

  assign rd_word   = ram[raddr[CW-1:0]];
  assign full      = (waddr[CW-1:0] == raddr[CW-1:0]) && (waddr[CW] != raddr[CW]);
  // In packet mode only words behind the commit pointer are visible to the reader.
  assign avail     = (MODE != 0) ? (raddr != caddr) : (raddr != waddr);
  assign rd        = out_ready & avail;
  assign din_ready = ~rst & (~full | rd);
  assign wr        = din_valid & din_ready;
  assign wr_eot    = wr & din_data[EOT_BIT];
  assign rd_eot    = rd & rd_word[EOT_BIT];
  assign waddr_nxt = wr ? waddr + ONE : waddr;
  assign raddr_nxt = rd ? raddr + ONE : raddr;

  // NOTE: the storage array is deliberately not reset; the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (wr) ram[waddr[CW-1:0]] <= din_data;
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waddr <= '0;
      raddr <= '0;
      caddr <= '0;
    end else begin
      waddr <= waddr_nxt;
      raddr <= raddr_nxt;
      if (MODE == 0) begin
        caddr <= waddr_nxt;
      end else if (wr_eot) begin
        caddr <= waddr + ONE;
      end else if (full && (caddr == raddr)) begin
        // A packet larger than the RAM is released as cut-through instead of deadlocking.
        caddr <= waddr;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt <= '0;
    end else begin
      case ({wr_eot, rd_eot})
        2'b10:   pkt_cnt <= pkt_cnt + ONE;
        2'b01:   pkt_cnt <= pkt_cnt - ONE;
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

`ifdef FIFO_PKT_LEVEL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) level <= '0;
    else     level <= waddr_nxt - raddr_nxt;
  end
`endif

  generate
    if (REGOUT != 0) begin : g_regout
      // The register reloads only when empty or being consumed, so a stalled word stays put.
      assign out_ready = ~dout_valid | dout_ready;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dout_valid <= 1'b0;
          dout_data  <= '0;
        end else if (out_ready) begin
          dout_valid <= avail;
          dout_data  <= rd_word;
        end
      end
    end else begin : g_comb
      assign out_ready  = dout_ready;
      assign dout_valid = avail;
      assign dout_data  = rd_word;
    end
  endgenerate

endmodule
